// File: rtl/world_mem_dp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// world_mem_dp_pkg: opcodes, world-state addresses, instruction layout, states
// Rev 1.0
// ---------------------------------------------------------------------------
package world_mem_dp_pkg;

  localparam int OP_NOP      = 0;
  localparam int OP_MEMREAD  = 1;
  localparam int OP_MEMWRITE = 2;
  localparam int OP_MEMADD   = 3;
  localparam int OP_CLEAR    = 4;

  localparam int ADDR_FOOD_X   = 0;
  localparam int ADDR_FOOD_Y   = 1;
  localparam int ADDR_POISON_X = 2;
  localparam int ADDR_POISON_Y = 3;

  localparam int RESULT_WIDTH = 16;

  // Instruction is {operand, addr, opcode} with the opcode in the LSBs
  function automatic int addr_lsb(input int opcode_width);
    return opcode_width;
  endfunction

  function automatic int operand_lsb(input int opcode_width, input int addr_width);
    return opcode_width + addr_width;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DATA  = 3'd3,
    S_ADD_WR   = 3'd4,
    S_WR       = 3'd5,
    S_CLR_LOOP = 3'd6,
    S_DONE     = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/world_mem_dp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// world_ram: single-port synchronous RAM, 1-cycle read latency, write-enable
// Rev 1.0
// ---------------------------------------------------------------------------
module world_ram
  import world_mem_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // A write cycle leaves rdata untouched so the port never reads and writes at once
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/world_mem_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// world_mem_dp: executes one {operand, addr, opcode} instruction per start edge
// Rev 1.0
// ---------------------------------------------------------------------------
module world_mem_dp
  import world_mem_dp_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                                       clock,
  input  logic                                       resetn,
  input  logic                                       start,
  input  logic [DATA_WIDTH+ADDR_WIDTH+OPCODE_WIDTH-1:0] instruction,
  output logic                                       finished,
  output logic [DATA_WIDTH-1:0]                      result,
  output logic                                       error
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int A_LSB  = addr_lsb(OPCODE_WIDTH);
  localparam int D_LSB  = operand_lsb(OPCODE_WIDTH, ADDR_WIDTH);

  state_e                  r_state, w_state_next;
  logic                    r_start_q;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [IDX_W-1:0]        r_addr;
  logic [DATA_WIDTH-1:0]   r_operand;
  logic [DATA_WIDTH-1:0]   r_sum, w_sum_next;
  logic [IDX_W-1:0]        r_clr_cnt, w_clr_cnt_next;
  logic                    w_finished_next, w_error_next;
  logic [DATA_WIDTH-1:0]   w_result_next;

  logic [OPCODE_WIDTH-1:0] w_op;
  logic [ADDR_WIDTH-1:0]   w_addr_full;
  logic [IDX_W-1:0]        w_addr_idx;
  logic [DATA_WIDTH-1:0]   w_operand;
  logic                    w_in_range, w_accept;

  logic                    w_ram_en, w_ram_we;
  logic [IDX_W-1:0]        w_ram_addr;
  logic [DATA_WIDTH-1:0]   w_ram_wdata, w_ram_rdata;

  assign w_op        = instruction[OPCODE_WIDTH-1:0];
  assign w_addr_full = instruction[A_LSB +: ADDR_WIDTH];
  assign w_addr_idx  = instruction[A_LSB +: IDX_W];
  assign w_operand   = instruction[D_LSB +: DATA_WIDTH];
  assign w_in_range  = {1'b0, w_addr_full} < (ADDR_WIDTH+1)'(DEPTH);
  assign w_accept    = start && !r_start_q && (r_state == S_IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      finished  <= 1'b1;
      result    <= '0;
      error     <= 1'b0;
      r_opcode  <= '0;
      r_addr    <= '0;
      r_operand <= '0;
      r_sum     <= '0;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= start;
      finished  <= w_finished_next;
      result    <= w_result_next;
      error     <= w_error_next;
      r_sum     <= w_sum_next;
      r_clr_cnt <= w_clr_cnt_next;
      if (w_accept) begin
        r_opcode  <= w_op;
        r_addr    <= w_addr_idx;
        r_operand <= w_operand;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_finished_next = finished;
    w_result_next   = result;
    w_error_next    = error;
    w_sum_next      = r_sum;
    w_clr_cnt_next  = r_clr_cnt;
    w_ram_en        = 1'b0;
    w_ram_we        = 1'b0;
    w_ram_addr      = r_addr;
    w_ram_wdata     = r_operand;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // NOP and undefined opcodes complete on the accepting edge; finished never drops
          if (w_op == OPCODE_WIDTH'(OP_NOP) || w_op > OPCODE_WIDTH'(OP_CLEAR)) begin
            w_state_next  = S_DONE;
            w_result_next = '0;
            w_error_next  = (w_op != OPCODE_WIDTH'(OP_NOP));
          end else begin
            w_finished_next = 1'b0;
            if (w_op == OPCODE_WIDTH'(OP_CLEAR) || !w_in_range)
              w_state_next = S_DECODE;
            else if (w_op == OPCODE_WIDTH'(OP_MEMWRITE))
              w_state_next = S_WR;
            else
              w_state_next = S_RD_ISSUE;
          end
        end
      end
      S_DECODE: begin
        if (r_opcode == OPCODE_WIDTH'(OP_CLEAR)) begin
          w_clr_cnt_next = '0;
          w_state_next   = S_CLR_LOOP;
        end else begin
          w_state_next    = S_DONE;
          w_result_next   = '0;
          w_error_next    = 1'b1;
          w_finished_next = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        w_ram_en     = 1'b1;
        w_state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (r_opcode == OPCODE_WIDTH'(OP_MEMREAD)) begin
          w_state_next    = S_DONE;
          w_result_next   = w_ram_rdata;
          w_error_next    = 1'b0;
          w_finished_next = 1'b1;
        end else begin
          w_sum_next   = w_ram_rdata + r_operand;
          w_state_next = S_ADD_WR;
        end
      end
      S_ADD_WR: begin
        w_ram_en        = 1'b1;
        w_ram_we        = 1'b1;
        w_ram_wdata     = r_sum;
        w_state_next    = S_DONE;
        w_result_next   = r_sum;
        w_error_next    = 1'b0;
        w_finished_next = 1'b1;
      end
      S_WR: begin
        w_ram_en        = 1'b1;
        w_ram_we        = 1'b1;
        w_state_next    = S_DONE;
        w_result_next   = r_operand;
        w_error_next    = 1'b0;
        w_finished_next = 1'b1;
      end
      S_CLR_LOOP: begin
        w_ram_en       = 1'b1;
        w_ram_we       = 1'b1;
        w_ram_addr     = r_clr_cnt;
        w_ram_wdata    = '0;
        w_clr_cnt_next = r_clr_cnt + IDX_W'(1);
        if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_next    = S_DONE;
          w_result_next   = DATA_WIDTH'(DEPTH);
          w_error_next    = 1'b0;
          w_finished_next = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Gating with resetn keeps an aborted CLEAR from committing the write in its reset cycle
  world_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clock (clock),
    .en    (w_ram_en && resetn),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_world_mem_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_world_mem_dp: randomized self-checking bench against a world-RAM model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_world_mem_dp;
  import world_mem_dp_pkg::*;

  localparam int DW       = 16;
  localparam int AW       = 9;
  localparam int DEPTH    = 256;
  localparam int OW       = 3;
  localparam int IW       = DW + AW + OW;
  localparam int MAX_WAIT = DEPTH + 20;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start;
  logic [IW-1:0] instruction;
  logic          finished;
  logic [DW-1:0] result;
  logic          error;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] model_mem [DEPTH];

  always #5 clock = ~clock;

  world_mem_dp #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .OPCODE_WIDTH (OW)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .instruction (instruction),
    .finished    (finished),
    .result      (result),
    .error       (error)
  );

  // Raises start for 'hold' edges and reports the first cycle after acceptance with finished=1
  task automatic run_op(input int op, input int addr, input logic [DW-1:0] operand,
                        input int hold, output int lat, output logic [DW-1:0] res,
                        output logic err);
    logic [AW-1:0] a;
    logic [OW-1:0] o;
    a = AW'(addr);
    o = OW'(op);
    @(negedge clock);
    instruction = {operand, a, o};
    start = 1'b1;
    @(posedge clock); #1;
    lat = 1;
    forever begin
      if (lat >= hold) start = 1'b0;
      if (finished === 1'b1) break;
      if (lat >= MAX_WAIT) break;
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    res = result;
    err = error;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start = 1'b0;
    instruction = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (finished !== 1'b1) begin n_fail++; $display("FAIL reset_finished: got %b want 1", finished); end
    n_cmp++;
    if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_write_held();
    int lat; logic [DW-1:0] res; logic err;
    run_op(OP_MEMWRITE, 5, 16'h1234, 2, lat, res, err);
    model_mem[5] = 16'h1234;
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL write_latency: got %0d want 2", lat); end
    n_cmp++;
    if (res !== 16'h1234) begin n_fail++; $display("FAIL write_result: got %h want 1234", res); end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL write_error: got %b want 0", err); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (finished !== 1'b1) begin n_fail++; $display("FAIL write_no_retrigger: got finished=%b want 1", finished); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_read();
    int lat; logic [DW-1:0] res; logic err;
    for (int i = 0; i < 2; i++) begin
      run_op(OP_MEMREAD, 5, 16'h0, 1, lat, res, err);
      n_cmp++;
      if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", lat); end
      n_cmp++;
      if (res !== model_mem[5]) begin n_fail++; $display("FAIL read_result: got %h want %h", res, model_mem[5]); end
    end
  endtask

  task automatic test_add_wrap();
    int lat; logic [DW-1:0] res; logic err;
    run_op(OP_MEMWRITE, 7, 16'hFFFF, 1, lat, res, err);
    model_mem[7] = 16'hFFFF;
    run_op(OP_MEMADD, 7, 16'h0002, 1, lat, res, err);
    model_mem[7] = model_mem[7] + 16'h0002;
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_cmp++;
    if (res !== 16'h0001) begin n_fail++; $display("FAIL add_wrap_result: got %h want 0001", res); end
    run_op(OP_MEMREAD, 7, 16'h0, 1, lat, res, err);
    n_cmp++;
    if (res !== model_mem[7]) begin n_fail++; $display("FAIL add_readback: got %h want %h", res, model_mem[7]); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [DW-1:0] res; logic err;
    logic [DW-1:0] v255, v44;
    v255 = DW'($urandom_range(1, 16'hFFFF));
    v44  = DW'($urandom_range(1, 16'hFFFF));
    run_op(OP_MEMWRITE, 255, v255, 1, lat, res, err);
    model_mem[255] = v255;
    run_op(OP_MEMWRITE, 44, v44, 1, lat, res, err);
    model_mem[44] = v44;
    for (int op = OP_MEMREAD; op <= OP_MEMADD; op++) begin
      run_op(op, 300, 16'hBEEF, 1, lat, res, err);
      n_cmp++;
      if (lat !== 2 || res !== '0 || err !== 1'b1)
        begin n_fail++; $display("FAIL oor_op%0d: got lat=%0d res=%h err=%b want lat=2 res=0000 err=1", op, lat, res, err); end
    end
    run_op(OP_MEMREAD, 255, 16'h0, 1, lat, res, err);
    n_cmp++;
    if (res !== model_mem[255] || err !== 1'b0)
      begin n_fail++; $display("FAIL oor_keep255: got %h err=%b want %h err=0", res, err, model_mem[255]); end
    run_op(OP_MEMREAD, 44, 16'h0, 1, lat, res, err);
    n_cmp++;
    if (res !== model_mem[44]) begin n_fail++; $display("FAIL oor_no_alias44: got %h want %h", res, model_mem[44]); end
  endtask

  task automatic test_clear();
    int lat; logic [DW-1:0] res; logic err;
    int probe [3] = '{0, 128, 255};
    run_op(OP_CLEAR, 0, 16'h0, 1, lat, res, err);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    n_cmp++;
    if (lat !== DEPTH + 2) begin n_fail++; $display("FAIL clear_latency: got %0d want %0d", lat, DEPTH + 2); end
    n_cmp++;
    if (res !== DW'(DEPTH) || err !== 1'b0)
      begin n_fail++; $display("FAIL clear_result: got %h err=%b want %h err=0", res, err, DW'(DEPTH)); end
    foreach (probe[i]) begin
      run_op(OP_MEMREAD, probe[i], 16'h0, 1, lat, res, err);
      n_cmp++;
      if (res !== 16'h0) begin n_fail++; $display("FAIL clear_read%0d: got %h want 0000", probe[i], res); end
    end
  endtask

  task automatic test_nop_undef();
    int lat; logic [DW-1:0] res; logic err;
    for (int op = 0; op < 8; op++) begin
      if (op >= OP_MEMREAD && op <= OP_CLEAR) continue;
      run_op(OP_MEMWRITE, 3, 16'hA5A5, 1, lat, res, err);
      model_mem[3] = 16'hA5A5;
      run_op(op, 3, 16'h5555, 1, lat, res, err);
      n_cmp++;
      if (lat !== 1 || res !== '0 || err !== (op != OP_NOP))
        begin n_fail++; $display("FAIL nop_op%0d: got lat=%0d res=%h err=%b want lat=1 res=0000 err=%0d", op, lat, res, err, op != OP_NOP); end
    end
    run_op(OP_MEMREAD, 3, 16'h0, 1, lat, res, err);
    n_cmp++;
    if (res !== model_mem[3]) begin n_fail++; $display("FAIL nop_no_write: got %h want %h", res, model_mem[3]); end
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] res; logic err;
    int op, addr, hold, exp_lat;
    logic [DW-1:0] operand, exp_res;
    logic exp_err;
    for (int n = 0; n < 60; n++) begin
      op      = OP_MEMREAD + int'($urandom_range(0, 2));
      addr    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 255));
      operand = DW'($urandom);
      hold    = int'($urandom_range(1, 3));
      if (addr >= DEPTH) begin
        exp_lat = 2; exp_res = '0; exp_err = 1'b1;
      end else if (op == OP_MEMWRITE) begin
        exp_lat = 2; exp_res = operand; exp_err = 1'b0;
        model_mem[addr] = operand;
      end else if (op == OP_MEMREAD) begin
        exp_lat = 3; exp_res = model_mem[addr]; exp_err = 1'b0;
      end else begin
        exp_lat = 4; exp_res = model_mem[addr] + operand; exp_err = 1'b0;
        model_mem[addr] = exp_res;
      end
      run_op(op, addr, operand, hold, lat, res, err);
      n_cmp++;
      if (lat !== exp_lat || res !== exp_res || err !== exp_err)
        begin n_fail++; $display("FAIL random_%0d op=%0d addr=%0d: got lat=%0d res=%h err=%b want lat=%0d res=%h err=%b",
                                 n, op, addr, lat, res, err, exp_lat, exp_res, exp_err); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int lat; logic [DW-1:0] res; logic err;
    int keep [4] = '{50, 51, 200, 255};
    int gone [2] = '{0, 47};
    foreach (keep[i]) begin
      run_op(OP_MEMWRITE, keep[i], DW'($urandom_range(1, 16'hFFFF)), 1, lat, res, err);
      model_mem[keep[i]] = res;
    end
    foreach (gone[i]) begin
      run_op(OP_MEMWRITE, gone[i], 16'h7777, 1, lat, res, err);
    end
    run_op(OP_MEMREAD, keep[0], 16'h0, 1, lat, res, err);
    @(negedge clock);
    instruction = {16'h0, 9'd0, 3'(OP_CLEAR)};
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k < 50; k++) begin @(posedge clock); #1; end
    n_cmp++;
    if (finished !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got finished=%b want 0", finished); end
    resetn = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (finished !== 1'b1 || result !== '0 || error !== 1'b0)
      begin n_fail++; $display("FAIL abort_outputs: got fin=%b res=%h err=%b want fin=1 res=0000 err=0", finished, result, error); end
    resetn = 1'b1;
    @(posedge clock); #1;
    run_op(OP_MEMWRITE, 10, 16'hC0DE, 1, lat, res, err);
    n_cmp++;
    if (lat !== 2 || res !== 16'hC0DE || err !== 1'b0)
      begin n_fail++; $display("FAIL abort_then_write: got lat=%0d res=%h err=%b want lat=2 res=c0de err=0", lat, res, err); end
    foreach (keep[i]) begin
      run_op(OP_MEMREAD, keep[i], 16'h0, 1, lat, res, err);
      n_cmp++;
      if (res !== model_mem[keep[i]]) begin n_fail++; $display("FAIL abort_kept%0d: got %h want %h", keep[i], res, model_mem[keep[i]]); end
    end
    foreach (gone[i]) begin
      run_op(OP_MEMREAD, gone[i], 16'h0, 1, lat, res, err);
      n_cmp++;
      if (res !== 16'h0) begin n_fail++; $display("FAIL abort_cleared%0d: got %h want 0000", gone[i], res); end
    end
  endtask

  initial begin
    test_reset();
    test_write_held();
    test_read();
    test_add_wrap();
    test_out_of_range();
    test_clear();
    test_nop_undef();
    test_random();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
